instr_encoder: RTL and testbench
================================

# instr_encoder

Two-stage pipelined instruction encoder that packs decoded operation fields into 32-bit SimpleRISC instruction words. It is the inverse of the core's immediate/branch-target decode path. For each request it:
- picks the 2-bit immediate modifier that reproduces the requested 32-bit immediate, or
- computes the 27-bit PC-relative branch offset.

It sits between the test-program/boot loader front end and instruction memory, with valid/ready handshakes on both sides.

## Interface
- ENC_NOP, 32'h6800_0000, word emitted in place of an unencodable request
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_opcode  input  5  opcode, placed in [31:27]
- in_is_branch  input  1  1: branch format (offset in [26:0]); 0: ALU/mem format
- in_imm_mode  input  1  I bit [26] for non-branch requests
- in_rd, in_rs1, in_rs2  input  4 each  register fields, placed in [25:22], [21:18], [17:14]
- in_imm  input  32  requested final immediate value
- in_pc, in_target  input  32  instruction address and branch destination
- out_valid  input→output  1  out_valid is an output: encoded word valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  encoded instruction
- out_err  output  1  request was unencodable
- out_err_code  output  2  00 none, 01 immediate unencodable, 10 branch out of range
- instr_cnt, err_cnt  output  16 each  statistics (see Configuration)

## Operation
- **S1 (classify)**
  - Registers the request and computes the modifier or offset.
  - Immediate rule, first match wins:
    - in_imm[31:15] all equal → mod 00, field in_imm[15:0].
    - in_imm[31:16]==0 → mod 01, field in_imm[15:0].
    - in_imm[15:0]==0 → mod 10, field in_imm[31:16].
    - Otherwise → error 01.
  - Branch rule:
    - off = in_target − in_pc, modulo 2^32, unshifted (decode adds the offset directly to pc).
    - Encodable iff off[31:26] all equal → field off[26:0].
    - Otherwise → error 10.
- **S2 (assemble)** builds the output word:
  - Branch: {opcode, off[26:0]}.
  - in_imm_mode=1: {opcode, 1, rd, rs1, mod, imm16}.
  - in_imm_mode=0: {opcode, 0, rd, rs1, rs2, 14'b0}.
  - Error: out_instr = ENC_NOP, out_err=1, out_err_code set.
- in_imm and in_imm_mode are ignored for branches. in_rs2 is ignored when in_imm_mode=1. in_target and in_pc are ignored for non-branches.

## Timing
- Latency: 2 cycles from the input handshake to out_valid, when there is no back-pressure.
- Throughput: 1 request per cycle.
- Handshake:
  - Transfer occurs when valid && ready is high at a rising clk edge.
  - out_instr, out_err and out_err_code hold stable while out_valid && !out_ready.
- Ready logic:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances. This is combinational from out_ready; there is no bubble.
- Back-pressure: with out_ready held low, exactly 2 requests are accepted, then in_ready drops.
- Simultaneous accept and emit in the same cycle: both occur, and occupancy is unchanged.
- Reset, whether idle or mid-operation:
  - Both stages are invalidated and in-flight requests are dropped.
  - out_valid=0, out_instr=0, out_err=0, out_err_code=0, instr_cnt=0, err_cnt=0, in_ready=1 after release.

## Configuration
- ENC_STATS_EN defined:
  - instr_cnt increments on every output handshake.
  - err_cnt increments on every output handshake with out_err=1.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- ENC_STATS_EN undefined: instr_cnt and err_cnt are tied to 0, and no counter flops are built.

## Test plan
- Register ALU: opcode 00000, I=0, rd=1, rs1=2, rs2=3, out_ready=1 → out_instr 32'h0048_C000 two cycles later, out_err=0.
- Immediate modes, each with opcode 00000, I=1, rd=1, rs1=2:
  - imm 32'h0000_1234 → 32'h0448_1234.
  - imm 32'h0000_8000 → 32'h0449_8000.
  - imm 32'hABCD_0000 → 32'h044A_ABCD.
  - imm 32'hFFFF_FFFF → 32'h0448_FFFF.
- Errors:
  - imm 32'h1234_5678 → out_instr 32'h6800_0000, out_err=1, code 01.
  - Branch pc 32'h100, target 32'h0400_0100 → ENC_NOP, code 10.
  - With ENC_STATS_EN: err_cnt=2.
- Branch: opcode 10010, pc 32'h100, target 32'h0C0 → 32'h97FF_FFC0; target 32'h140 → 32'h9000_0040.
- Back-pressure: stream 4 requests with out_ready=0 → in_ready low after 2 accepts and out_instr stable; release out_ready → all 4 words emitted in order on consecutive cycles, instr_cnt=4.
- Reset mid-stream: assert rst_n=0 with both stages full → out_valid falls immediately (asynchronously), counters read 0, and the first post-reset request is emitted correctly after 2 cycles.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded operation fields into 32-bit SimpleRISC words
// (immediate-modifier selection, PC-relative branch offset), 2-stage pipeline.
// Latency 2 cycles from input handshake to out_valid; 1 request/cycle throughput.
// Backpressure: in_ready is combinational from out_ready, so there is no bubble;
// with out_ready low, two requests fill the pipe and then in_ready drops.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake
//   in_opcode, in_is_branch, in_imm_mode, in_rd, in_rs1, in_rs2,
//   in_imm, in_pc, in_target        decoded request fields
//   out_valid/out_ready             encoded-word handshake
//   out_instr, out_err, out_err_code  encoded word and error status
//   instr_cnt, err_cnt              statistics counters
// Optional feature macro: ENC_STATS_EN builds the saturating counters;
// without it both counters are tied to zero.

module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic        in_is_branch,
  input  logic        in_imm_mode,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [1:0]  out_err_code,
  output logic [15:0] instr_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] ENC_NOP     = 32'h6800_0000;
  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_IMM     = 2'b01;
  localparam logic [1:0]  ERR_BRANCH  = 2'b10;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic r_s1_vld;
  logic r_s2_vld;
  logic w_s2_adv;
  logic w_s1_adv;

  assign w_s2_adv = !r_s2_vld || out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign in_ready = w_s1_adv;

  // ---------------------------------------------------------------------------
  // S1 classification (combinational on the incoming request)
  // ---------------------------------------------------------------------------
  logic        w_imm_sext;   // value fits as sign-extended 16 bits
  logic        w_imm_zext;   // value fits as zero-extended 16 bits
  logic        w_imm_high;   // value is a 16-bit quantity shifted up by 16
  logic [31:0] w_off;
  logic        w_off_ok;
  logic [1:0]  w_mod;
  logic [15:0] w_field;
  logic [1:0]  w_code;

  assign w_imm_sext = (&in_imm[31:15]) || !(|in_imm[31:15]);
  assign w_imm_zext = !(|in_imm[31:16]);
  assign w_imm_high = !(|in_imm[15:0]);

  // Decode adds the offset straight to pc, so no shift is applied here.
  assign w_off    = in_target - in_pc;
  assign w_off_ok = (&w_off[31:26]) || !(|w_off[31:26]);

  // Modifier priority matters: a value such as 0 matches every rule and must
  // take mod 00 so the encoding is canonical.
  always_comb begin
    w_mod   = 2'b00;
    w_field = in_imm[15:0];
    w_code  = ERR_NONE;
    if (in_is_branch) begin
      if (!w_off_ok) w_code = ERR_BRANCH;
    end else if (in_imm_mode) begin
      if (w_imm_sext) begin
        w_mod = 2'b00;
      end else if (w_imm_zext) begin
        w_mod = 2'b01;
      end else if (w_imm_high) begin
        w_mod   = 2'b10;
        w_field = in_imm[31:16];
      end else begin
        w_code = ERR_IMM;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  logic [4:0]  r_s1_opcode;
  logic        r_s1_is_branch;
  logic        r_s1_imm_mode;
  logic [3:0]  r_s1_rd;
  logic [3:0]  r_s1_rs1;
  logic [3:0]  r_s1_rs2;
  logic [1:0]  r_s1_mod;
  logic [15:0] r_s1_field;
  logic [26:0] r_s1_off;
  logic [1:0]  r_s1_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld       <= 1'b0;
      r_s1_opcode    <= '0;
      r_s1_is_branch <= 1'b0;
      r_s1_imm_mode  <= 1'b0;
      r_s1_rd        <= '0;
      r_s1_rs1       <= '0;
      r_s1_rs2       <= '0;
      r_s1_mod       <= '0;
      r_s1_field     <= '0;
      r_s1_off       <= '0;
      r_s1_code      <= ERR_NONE;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_opcode    <= in_opcode;
        r_s1_is_branch <= in_is_branch;
        r_s1_imm_mode  <= in_imm_mode;
        r_s1_rd        <= in_rd;
        r_s1_rs1       <= in_rs1;
        r_s1_rs2       <= in_rs2;
        r_s1_mod       <= w_mod;
        r_s1_field     <= w_field;
        r_s1_off       <= w_off[26:0];
        r_s1_code      <= w_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 assembly
  // ---------------------------------------------------------------------------
  logic [31:0] w_word;

  always_comb begin
    w_word = ENC_NOP;
    if (r_s1_code == ERR_NONE) begin
      if (r_s1_is_branch)
        w_word = {r_s1_opcode, r_s1_off};
      else if (r_s1_imm_mode)
        w_word = {r_s1_opcode, 1'b1, r_s1_rd, r_s1_rs1, r_s1_mod, r_s1_field};
      else
        w_word = {r_s1_opcode, 1'b0, r_s1_rd, r_s1_rs1, r_s1_rs2, 14'b0};
    end
  end

  logic [31:0] r_s2_instr;
  logic        r_s2_err;
  logic [1:0]  r_s2_code;

  // Output fields only reload when S2 advances, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
      r_s2_code  <= ERR_NONE;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_instr <= w_word;
        r_s2_err   <= (r_s1_code != ERR_NONE);
        r_s2_code  <= r_s1_code;
      end
    end
  end

  assign out_valid    = r_s2_vld;
  assign out_instr    = r_s2_instr;
  assign out_err      = r_s2_err;
  assign out_err_code = r_s2_code;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef ENC_STATS_EN
  logic        w_out_hs;
  logic [15:0] r_instr_cnt;
  logic [15:0] r_err_cnt;

  assign w_out_hs = r_s2_vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_out_hs) begin
      if (r_instr_cnt != 16'hFFFF) r_instr_cnt <= r_instr_cnt + 16'd1;
      if (r_s2_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign instr_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; directed vectors,
// back-pressure, reset mid-stream and randomized traffic against a reference model.
// Expected words are queued at input handshake and popped by an output monitor.

module tb_instr_encoder;

  localparam logic [31:0] ENC_NOP = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic        in_is_branch;
  logic        in_imm_mode;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, in_pc, in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic [15:0] instr_cnt, err_cnt;

  instr_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_is_branch (in_is_branch),
    .in_imm_mode  (in_imm_mode),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .in_pc        (in_pc),
    .in_target    (in_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_err      (out_err),
    .out_err_code (out_err_code),
    .instr_cnt    (instr_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic        br;
    logic        mode;
    logic [3:0]  rd, rs1, rs2;
    logic [31:0] imm, pc, tgt;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cyc_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_instr_cnt = 0;
  int   exp_err_cnt = 0;
  bit   lat_chk = 0;
  bit   rnd_or = 0;
  bit   or_fixed = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: range tests on the signed/unsigned value, plain arithmetic assembly.
  function automatic exp_t model(input req_t r);
    exp_t   e;
    longint s;
    longint w;
    longint mod;
    longint fld;
    logic [31:0] off;
    e.cyc = 0;
    e.code = 2'd0;
    e.instr = ENC_NOP;
    w = 0;
    if (r.br) begin
      off = r.tgt - r.pc;
      s = longint'($signed(off));
      if (s >= -67108864 && s <= 67108863) begin
        w = longint'(r.opc) * 134217728 + (longint'(off) % 134217728);
        e.instr = 32'(w);
      end else begin
        e.code = 2'd2;
      end
    end else if (r.mode) begin
      s = longint'($signed(r.imm));
      mod = 0;
      fld = 0;
      if (s >= -32768 && s <= 32767) begin
        mod = 0; fld = longint'(r.imm) % 65536;
      end else if (longint'(r.imm) < 65536) begin
        mod = 1; fld = longint'(r.imm);
      end else if (longint'(r.imm) % 65536 == 0) begin
        mod = 2; fld = longint'(r.imm) / 65536;
      end else begin
        e.code = 2'd1;
      end
      if (e.code == 2'd0) begin
        w = longint'(r.opc) * 134217728 + 67108864 + longint'(r.rd) * 4194304 +
            longint'(r.rs1) * 262144 + mod * 65536 + fld;
        e.instr = 32'(w);
      end
    end else begin
      w = longint'(r.opc) * 134217728 + longint'(r.rd) * 4194304 +
          longint'(r.rs1) * 262144 + longint'(r.rs2) * 16384;
      e.instr = 32'(w);
    end
    return e;
  endfunction

  function automatic req_t mk(input logic [4:0] opc, input logic br, input logic mode,
                              input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] tgt);
    req_t r;
    r.opc = opc; r.br = br; r.mode = mode; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.imm = imm; r.pc = pc; r.tgt = tgt;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    logic [31:0] off;
    r.opc  = 5'($urandom_range(0, 31));
    r.br   = ($urandom_range(0, 2) == 0);
    r.mode = $urandom_range(0, 1) == 1;
    r.rd   = 4'($urandom_range(0, 15));
    r.rs1  = 4'($urandom_range(0, 15));
    r.rs2  = 4'($urandom_range(0, 15));
    r.pc   = $urandom() & 32'hFFFF_FFFC;
    case ($urandom_range(0, 7))
      0: r.imm = 32'(int'($urandom_range(0, 65535)) - 32768);
      1: r.imm = 32'($urandom_range(0, 65535));
      2: r.imm = $urandom() & 32'hFFFF_0000;
      3: r.imm = 32'h0000_7FFF;
      4: r.imm = 32'hFFFF_8000;
      5: r.imm = 32'hFFFF_7FFF;
      6: r.imm = 32'h0001_0000;
      default: r.imm = $urandom();
    endcase
    case ($urandom_range(0, 6))
      0: off = 32'(int'($urandom_range(0, 2000)) - 1000);
      1: off = 32'h03FF_FFFF;
      2: off = 32'hFC00_0000;
      3: off = 32'h0400_0000;
      4: off = 32'hFBFF_FFFF;
      5: off = 32'(int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000);
      default: off = $urandom();
    endcase
    r.tgt = r.pc + off;
    return r;
  endfunction

  // out_ready is driven from one place only, a little after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : or_fixed;
    end
  end

  // Output monitor: pops the scoreboard on every output handshake and checks
  // that a stalled output does not change.
  initial begin : monitor
    exp_t        e;
    bit          held;
    logic [31:0] h_instr;
    logic [2:0]  h_err;
    held = 0;
    h_instr = '0;
    h_err = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_instr", out_instr, h_instr);
          chk("hold_err", {29'b0, out_err, out_err_code}, {29'b0, h_err});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %h, expected no output (cycle %0d)", out_instr, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("instr", out_instr, e.instr);
            chk("err_flag", {31'b0, out_err}, {31'b0, (e.code != 2'd0)});
            chk("err_code", {30'b0, out_err_code}, {30'b0, e.code});
            if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
            pop_cyc_q.push_back(cyc);
            exp_instr_cnt++;
            if (e.code != 2'd0) exp_err_cnt++;
          end
        end
        held = out_valid && !out_ready;
        h_instr = out_instr;
        h_err = {out_err, out_err_code};
      end
    end
  end

  task automatic drive(input req_t r);
    in_opcode = r.opc; in_is_branch = r.br; in_imm_mode = r.mode;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_imm = r.imm; in_pc = r.pc; in_target = r.tgt;
    in_valid = 1'b1;
  endtask

  // Presents a request until accepted; expected result is queued at the
  // negedge before the accepting edge (in_ready is stable by then).
  task automatic send(input req_t r, input logic [31:0] ei, input logic [1:0] ec);
    exp_t e;
    drive(r);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = ei; e.code = ec; e.cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout: in_ready stayed 0, expected an accept (cycle %0d)", cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input req_t r);
    exp_t e;
    e = model(r);
    send(r, e.instr, e.code);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (sb_q.size() == 0) begin
        idle(2);
        return;
      end
      idle(1);
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb_q.size());
  endtask

  task automatic chk_counters(input string tag);
`ifdef ENC_STATS_EN
    chk({tag, "_instr_cnt"}, {16'b0, instr_cnt}, 32'(exp_instr_cnt));
    chk({tag, "_err_cnt"}, {16'b0, err_cnt}, 32'(exp_err_cnt));
`else
    chk({tag, "_instr_cnt"}, {16'b0, instr_cnt}, 32'd0);
    chk({tag, "_err_cnt"}, {16'b0, err_cnt}, 32'd0);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   base;
    req_t r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    drive(mk(5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0));
    in_valid = 1'b0;
    idle(2);

    // Reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {29'b0, out_err, out_err_code}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk_counters("rst");
    rst_n = 1'b1;
    idle(1);

    // Directed vectors, back-to-back, out_ready high
    lat_chk = 1;
    send(mk(5'b00000, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 32'hDEAD_BEEF, 32'h0, 32'h0), 32'h0048_C000, 2'b00);
    send(mk(5'b00000, 1'b0, 1'b1, 4'd1, 4'd2, 4'd15, 32'h0000_1234, 32'h0, 32'h0), 32'h0448_1234, 2'b00);
    send(mk(5'b00000, 1'b0, 1'b1, 4'd1, 4'd2, 4'd15, 32'h0000_8000, 32'h0, 32'h0), 32'h0449_8000, 2'b00);
    send(mk(5'b00000, 1'b0, 1'b1, 4'd1, 4'd2, 4'd15, 32'hABCD_0000, 32'h0, 32'h0), 32'h044A_ABCD, 2'b00);
    send(mk(5'b00000, 1'b0, 1'b1, 4'd1, 4'd2, 4'd15, 32'hFFFF_FFFF, 32'h0, 32'h0), 32'h0448_FFFF, 2'b00);
    send(mk(5'b00000, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 32'h1234_5678, 32'h0, 32'h0), ENC_NOP, 2'b01);
    send(mk(5'b10010, 1'b1, 1'b0, 4'd5, 4'd6, 4'd7, 32'h1234_5678, 32'h100, 32'h0400_0100), ENC_NOP, 2'b10);
    send(mk(5'b10010, 1'b1, 1'b1, 4'd5, 4'd6, 4'd7, 32'h1234_5678, 32'h100, 32'h0C0), 32'h97FF_FFC0, 2'b00);
    send(mk(5'b10010, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h100, 32'h140), 32'h9000_0040, 2'b00);
    wait_drain();
    chk_counters("directed");
    lat_chk = 0;

    // Idle reset pulse, then back-pressure with out_ready low
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_instr_cnt = 0;
    exp_err_cnt = 0;
    or_fixed = 0;
    idle(1);
    send(mk(5'd1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 32'h0, 32'h0, 32'h0), 32'h0844_4000, 2'b00);
    send(mk(5'd2, 1'b0, 1'b1, 4'd2, 4'd2, 4'd0, 32'h0000_00FF, 32'h0, 32'h0), 32'h1488_00FF, 2'b00);
    drive(mk(5'd3, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3, 32'h0, 32'h0, 32'h0));
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    or_fixed = 1;
    base = pop_cyc_q.size();
    send(mk(5'd3, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3, 32'h0, 32'h0, 32'h0), 32'h18CC_C000, 2'b00);
    send(mk(5'd4, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h200, 32'h180), 32'h27FF_FF80, 2'b00);
    wait_drain();
    chk("bp_emitted", 32'(pop_cyc_q.size() - base), 32'd4);
    if (pop_cyc_q.size() >= base + 4)
      for (int k = 1; k < 4; k++)
        chk("bp_consecutive", 32'(pop_cyc_q[base + k] - pop_cyc_q[base + k - 1]), 32'd1);
    chk_counters("bp");

    // Reset with both stages full
    or_fixed = 0;
    idle(1);
    send(mk(5'd5, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 32'h0, 32'h0, 32'h0), 32'h2844_4000, 2'b00);
    send(mk(5'd6, 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 32'h7777_7777, 32'h0, 32'h0), ENC_NOP, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    chk("midrst_instr_cnt", {16'b0, instr_cnt}, 32'd0);
    chk("midrst_err_cnt", {16'b0, err_cnt}, 32'd0);
    sb_q.delete();
    exp_instr_cnt = 0;
    exp_err_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_fixed = 1;
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    idle(1);
    lat_chk = 1;
    send(mk(5'd7, 1'b0, 1'b1, 4'd9, 4'd4, 4'd0, 32'hFFFF_8000, 32'h0, 32'h0), 32'h3E50_8000, 2'b00);
    wait_drain();
    chk_counters("postrst");
    lat_chk = 0;

    // Randomized traffic with random back-pressure
    rnd_or = 1;
    for (int i = 0; i < 300; i++) begin
      r = rnd_req();
      send_m(r);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rnd_or = 0;
    or_fixed = 1;
    idle(1);
    wait_drain();
    chk_counters("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
